decoder_nx_pipe: RTL and testbench

//   Parametrised, registered N-to-M binary decoder; successor to the fixed 3-to-8 combinational decoder.

---
 rtl/decoder_nx_pipe.sv | 135 +++++++++++++
 tb/tb_decoder_nx_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nx_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decoder_nx_pipe
// Description : Parametrised, registered N-to-M binary decoder with a
//               valid/ready handshake on both sides. It produces a one-hot or
//               thermometer vector one cycle after a code is accepted, and it
//               counts the accepted codes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   IN_W      width of the binary code input
//   NUM_OUT   number of decoded outputs (1 <= NUM_OUT <= 2**IN_W)
//   CNT_W     width of the accepted-transfer counter
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   in_valid   in   1        code/mode valid
//   in_ready   out  1        block can accept this cycle
//   in_code    in   IN_W     binary code
//   in_mode    in   1        0 = one-hot, 1 = thermometer
//   out_valid  out  1        out_data valid
//   out_ready  in   1        downstream accepts out_data
//   out_data   out  NUM_OUT  decoded vector
//   out_err    out  1        code out of range (range check build only)
//   acc_cnt    out  CNT_W    number of accepted input transfers, wraps
// Build option
//   DEC_ERR_CHK_EN  When defined, an out-of-range code decodes to all zeros
//                   and raises out_err for that beat. When undefined there is
//                   no range check and out_err is tied low.
// ============================================================================
module decoder_nx_pipe #(
  parameter int IN_W    = 3,
  parameter int NUM_OUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_code,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_data,
  output logic               out_err,
  output logic [CNT_W-1:0]   acc_cnt
);

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic               r_out_valid;
  logic [NUM_OUT-1:0] r_out_data;
  logic               r_out_err;
  logic [CNT_W-1:0]   r_acc_cnt;
  logic               w_accept;

  // The single output slot frees up in the same cycle it drains, so a new
  // code can be taken every cycle with no bubble.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  // The code is zero-extended to 32 bits before comparing against each output
  // index, so no upper bit of the code is lost when NUM_OUT < 2**IN_W.
  logic [31:0]        w_code_ext;
  logic [NUM_OUT-1:0] w_onehot;
  logic [NUM_OUT-1:0] w_therm;
  logic [NUM_OUT-1:0] w_dec;
  logic               w_err;

  assign w_code_ext = 32'(in_code);

  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_dec
      assign w_onehot[gi] = (w_code_ext == 32'(gi));
      assign w_therm[gi]  = (32'(gi) <= w_code_ext);
    end
  endgenerate

`ifdef DEC_ERR_CHK_EN
  logic w_out_of_range;

  assign w_out_of_range = (w_code_ext >= 32'(NUM_OUT));
  // An out-of-range code yields all zeros in either mode and is flagged.
  assign w_dec = w_out_of_range ? '0 : (in_mode ? w_therm : w_onehot);
  assign w_err = w_out_of_range;
`else
  // Without the range check an out-of-range code falls out of the index
  // compare: all zeros for one-hot, all ones for thermometer.
  assign w_dec = in_mode ? w_therm : w_onehot;
  assign w_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Output register stage
  // --------------------------------------------------------------------------
  // Data and error load only on accept. Code and mode are therefore ignored
  // (including unknown values) whenever no transfer happens, and they stay
  // stable while the downstream applies backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_dec;
      r_out_err   <= w_err;
    end else if (out_ready) begin
      // Drain with nothing new: valid drops, data keeps its last value.
      r_out_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Accepted-transfer counter (wraps naturally)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_cnt <= '0;
    end else if (w_accept) begin
      r_acc_cnt <= r_acc_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign acc_cnt   = r_acc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decoder_nx_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_nx_pipe
// Description : Self-checking bench for decoder_nx_pipe. Instance A uses the
//               default parameters and is checked through a scoreboard queue.
//               Instance B (NUM_OUT=6, CNT_W=4) covers out-of-range codes and
//               counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_nx_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_err;
  logic [2:0] a_in_code;
  logic [7:0] a_out_data, a_acc_cnt;

  // Instance B: NUM_OUT=6, CNT_W=4
  logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_err;
  logic [2:0] b_in_code;
  logic [5:0] b_out_data;
  logic [3:0] b_acc_cnt;

  decoder_nx_pipe #(.IN_W(3), .NUM_OUT(8), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_in_code), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_err(a_out_err), .acc_cnt(a_acc_cnt)
  );

  decoder_nx_pipe #(.IN_W(3), .NUM_OUT(6), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_err(b_out_err), .acc_cnt(b_acc_cnt)
  );

`ifdef DEC_ERR_CHK_EN
  localparam logic       C_OOR_ERR   = 1'b1;
  localparam logic [5:0] C_OOR_THERM = 6'h00;
`else
  localparam logic       C_OOR_ERR   = 1'b0;
  localparam logic [5:0] C_OOR_THERM = 6'h3F;
`endif

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference decode for the 8-output instance, written as shifts.
  function automatic logic [7:0] model_a(input logic [2:0] code, input logic mode);
    if (mode) return 8'hFF >> (3'd7 - code);
    return 8'h01 << code;
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard for instance A
  // --------------------------------------------------------------------------
  logic [8:0] sb_q[$];
  logic [7:0] a_exp_data;
  logic       a_exp_err;
  int         a_acc_model = 0;
  logic       mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      logic [8:0] e;
      check("acc_cnt_track", 32'(a_acc_cnt), 32'(a_acc_model[7:0]));
      if (a_out_valid && a_out_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got data 0x%0h, expected no output", a_out_data);
        end else begin
          e = sb_q.pop_front();
          check("sb_data", 32'(a_out_data), 32'(e[7:0]));
          check("sb_err", 32'(a_out_err), 32'(e[8]));
        end
      end
      if (a_in_valid && a_in_ready) begin
        sb_q.push_back({a_exp_err, a_exp_data});
        a_acc_model++;
      end
    end
  end

  typedef struct {
    logic [2:0] code;
    logic       mode;
    logic [7:0] data;
  } vec_a_t;

  typedef struct {
    logic [2:0] code;
    logic       mode;
    logic [5:0] data;
    logic       err;
  } vec_b_t;

  vec_a_t a_vec[13];
  vec_b_t b_vec[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Vectors for A: codes 0..7 one-hot, then thermometer samples
    for (int i = 0; i < 8; i++) begin
      a_vec[i].code = 3'(i);
      a_vec[i].mode = 1'b0;
    end
    a_vec[0].data = 8'h01; a_vec[1].data = 8'h02; a_vec[2].data = 8'h04; a_vec[3].data = 8'h08;
    a_vec[4].data = 8'h10; a_vec[5].data = 8'h20; a_vec[6].data = 8'h40; a_vec[7].data = 8'h80;
    a_vec[8]  = '{3'd0, 1'b1, 8'h01};
    a_vec[9]  = '{3'd3, 1'b1, 8'h0F};
    a_vec[10] = '{3'd7, 1'b1, 8'hFF};
    a_vec[11] = '{3'd5, 1'b1, 8'h3F};
    a_vec[12] = '{3'd2, 1'b0, 8'h04};

    // Vectors for B: in-range and out-of-range codes
    b_vec[0] = '{3'd7, 1'b0, 6'h00, C_OOR_ERR};
    b_vec[1] = '{3'd7, 1'b1, C_OOR_THERM, C_OOR_ERR};
    b_vec[2] = '{3'd6, 1'b0, 6'h00, C_OOR_ERR};
    b_vec[3] = '{3'd5, 1'b1, 6'h3F, 1'b0};
    b_vec[4] = '{3'd4, 1'b0, 6'h10, 1'b0};
    b_vec[5] = '{3'd2, 1'b1, 6'h07, 1'b0};

    a_in_valid = 0; a_in_code = 0; a_in_mode = 0; a_out_ready = 1;
    a_exp_data = 0; a_exp_err = 0;
    b_in_valid = 0; b_in_code = 0; b_in_mode = 0; b_out_ready = 1;

    // ---------------- Reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_out_data", 32'(a_out_data), 0);
    check("rst_out_err", 32'(a_out_err), 0);
    check("rst_acc_cnt", 32'(a_acc_cnt), 0);
    rst = 0;
    @(negedge clk);
    check("rst_in_ready", 32'(a_in_ready), 1);
    mon_en = 1;
    @(posedge clk); #1;

    // ---------------- T5: B counter wrap, 17 accepts ----------------
    b_in_valid = 1; b_in_code = 3'd1; b_in_mode = 0;
    repeat (17) begin
      @(posedge clk); #1;
    end
    b_in_valid = 0;
    check("b_wrap_acc_cnt", 32'(b_acc_cnt), 1);

    // ---------------- T4: B out-of-range table ----------------
    for (int k = 0; k < 6; k++) begin
      b_in_valid = 1; b_in_code = b_vec[k].code; b_in_mode = b_vec[k].mode;
      @(posedge clk); #1;
      b_in_valid = 0;
      check("b_out_valid", 32'(b_out_valid), 1);
      check("b_out_data", 32'(b_out_data), 32'(b_vec[k].data));
      check("b_out_err", 32'(b_out_err), 32'(b_vec[k].err));
    end

    // ---------------- T1/T2: A table, back-to-back ----------------
    for (int k = 0; k < 13; k++) begin
      a_in_valid = 1; a_in_code = a_vec[k].code; a_in_mode = a_vec[k].mode;
      a_exp_data = a_vec[k].data; a_exp_err = 0;
      @(negedge clk);
      if (k > 0) check("a_stream_valid", 32'(a_out_valid), 1);
      @(posedge clk); #1;
    end
    a_in_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("a_drain_valid", 32'(a_out_valid), 0);
    check("a_drain_hold", 32'(a_out_data), 32'(8'h04));
    check("a_table_acc", 32'(a_acc_cnt), 13);
    @(posedge clk); #1;

    // ---------------- T3: backpressure ----------------
    a_in_valid = 1; a_in_code = 3'd5; a_in_mode = 0; a_exp_data = 8'h20; a_exp_err = 0;
    @(posedge clk); #1;
    a_in_code = 3'd2; a_exp_data = 8'h04; a_out_ready = 0;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", 32'(a_in_ready), 0);
      check("bp_out_valid", 32'(a_out_valid), 1);
      check("bp_out_data", 32'(a_out_data), 32'(8'h20));
      @(posedge clk); #1;
    end
    a_out_ready = 1;
    @(posedge clk); #1;
    a_in_valid = 0;
    @(negedge clk);
    check("bp_release_data", 32'(a_out_data), 32'(8'h04));
    check("bp_acc_cnt", 32'(a_acc_cnt), 15);
    @(posedge clk); #1;

    // ---------------- Random traffic ----------------
    for (int k = 0; k < 80; k++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_in_code   = 3'($urandom);
      a_in_mode   = 1'($urandom);
      a_exp_data  = model_a(a_in_code, a_in_mode);
      a_exp_err   = 0;
      a_out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    a_in_valid = 0; a_out_ready = 1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("sb_drained", 32'(sb_q.size()), 0);

    // ---------------- T6: reset while held ----------------
    a_in_valid = 1; a_in_code = 3'd6; a_in_mode = 0; a_exp_data = 8'h40; a_exp_err = 0;
    @(posedge clk); #1;
    a_in_valid = 0; a_out_ready = 0;
    @(posedge clk); #1;
    @(negedge clk);
    #2;
    mon_en = 0;
    rst = 1;
    #1;
    check("mid_rst_out_valid", 32'(a_out_valid), 0);
    check("mid_rst_out_data", 32'(a_out_data), 0);
    check("mid_rst_acc_cnt", 32'(a_acc_cnt), 0);
    check("mid_rst_b_acc_cnt", 32'(b_acc_cnt), 0);
    sb_q.delete();
    a_acc_model = 0;
    @(posedge clk); #1;
    rst = 0;
    mon_en = 1;
    a_out_ready = 1;
    a_in_valid = 1; a_in_code = 3'd3; a_in_mode = 1; a_exp_data = 8'h0F; a_exp_err = 0;
    @(posedge clk); #1;
    a_in_valid = 0;
    @(negedge clk);
    check("post_rst_data", 32'(a_out_data), 32'(8'h0F));
    @(posedge clk); #1;
    check("post_rst_acc", 32'(a_acc_cnt), 1);
    check("post_rst_sb_empty", 32'(sb_q.size()), 0);

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
